fadd16_seq: RTL and testbench
=============================

Name: fadd16_seq

Overview:
- Multi-cycle sequencer for the FloatAdd half-precision (binary16) adder datapath.
- Accepts one operand pair per valid/ready handshake and steps it through ALIGN, ADD, NORM and PACK.
- Drives the shared 11-bit leading-zero detector (lzd11, instantiated outside this block) during NORM.
- Returns the packed sum on an output valid/ready handshake. Exactly one operation is in flight at a time.

Parameters:
- EXP_W, 5, exponent width
- MAN_W, 10, stored mantissa width (datapath significand is MAN_W+1 = 11 bits including the hidden bit)
- POS_W, 4, width of the leading-zero count from lzd11

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- a  in  16  operand A, binary16
- b  in  16  operand B, binary16
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- sum  out  16  packed result
- busy  out  1  high in every state except IDLE
- lzd_in  out  11  significand presented to the external lzd11
- lzd_pos  in  4  leading-zero count from lzd11, combinational; 11 when lzd_in == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, and overrides everything, including mid-operation.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, sum = 16'h0000, lzd_in = 0. Any in-flight operation is discarded.
- FSM transitions:
  - IDLE -> ALIGN on in_valid & in_ready. a and b are registered on this edge.
  - ALIGN -> ADD -> NORM -> PACK -> DONE unconditionally.
  - DONE -> IDLE on out_ready.
- Latency: out_valid rises exactly 5 cycles after the accept edge. Latency is fixed; special operands take the same path with no bypass.
- in_ready = (state == IDLE). No input is accepted in the cycle DONE is left, so throughput is at most 1 result per 6 cycles.
- DONE holds out_valid = 1 and sum stable until out_ready. out_ready while out_valid = 0 is ignored.
- ALIGN:
  - Unpack both operands; hidden bit = 1 when exp != 0.
  - Denormal inputs (exp == 0) are flushed to signed zero.
  - Swap so the larger-magnitude operand sits in the big slot.
  - Right-shift the small significand by the exponent difference (saturate at 14).
  - Keep guard, round and sticky bits.
- ADD:
  - Same signs: add significands into a 12-bit result.
  - Different signs: subtract small from big; the result is non-negative by construction.
  - Result sign = sign of the big operand.
- NORM:
  - Carry (bit 11) set: shift right 1, exp + 1, with the shifted-out bit folded into sticky.
  - Otherwise: lzd_in = sum[10:0], shift left by lzd_pos, exp - lzd_pos.
  - lzd_in is driven only in NORM and is 0 elsewhere.
- PACK, in priority order:
  - Any NaN input, or inf + (-inf): 16'h7E00.
  - Otherwise any inf input: that inf.
  - Zero significand: 16'h0000. Exact cancellation gives +0; the sum of two -0 operands gives 16'h8000.
  - exp >= 31 after rounding: inf with the result sign.
  - exp <= 0: signed zero (flush).
  - Otherwise: {sign, exp, man[9:0]}.
- Rounding: truncation unless FADD_RNE_EN is defined.
- Width rule: the exponent is held in EXP_W+2 signed bits internally, so overflow and underflow are detected without wrap.

Optional Feature:
- Macro: FADD_RNE_EN.
- Defined: round to nearest, ties to even, in PACK using guard/round/sticky. A rounding carry renormalises (exp + 1) and may overflow to inf.
- Undefined: truncate; guard/round/sticky logic is not compiled. Latency is identical either way.

Decomposition:
- Package fadd16_pkg holds:
  - state enum (IDLE, ALIGN, ADD, NORM, PACK, DONE)
  - EXP_BIAS = 15, EXP_MAX = 31, QNAN = 16'h7E00
  - unpacked-operand struct {sign, exp, sig[10:0]}
- lzd11 stays external and shared via lzd_in/lzd_pos.
- One natural sub-module: fadd16_align, the combinational swap plus shifter with sticky generation, instantiated in ALIGN.

Test Plan:
- 3C00 + 3C00: result 4000, out_valid exactly 5 cycles after accept, in_ready low throughout.
- 3C01 + BC00 (massive cancellation): lzd_in = 11'b00000000001 in NORM, lzd_pos = 10, result 1400.
- 3C00 + 3800: 3E00. 3C00 + BC00: 0000. 8000 + 8000: 8000.
- 7BFF + 7BFF: 7C00. 7C00 + FC00: 7E00. 0001 (denormal) + 0000: 0000.
- Backpressure: out_ready held low 10 cycles gives sum/out_valid stable and in_valid ignored. A pulse of out_ready gives IDLE the next cycle.
- rst_n low during NORM gives out_valid = 0, in_ready = 1, sum = 0000 next cycle. A fresh 3C00 + 3C00 then completes normally.

Source files
------------

// File: rtl/fadd16_pkg.sv
// Shared types and constants for the sequential binary16 adder.
// Holds the FSM state encoding, IEEE half-precision constants and the
// unpacked-operand struct used by the align stage.
package fadd16_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int          EXP_BIAS = 15;
  localparam int          EXP_MAX  = 2 * EXP_BIAS + 1;
  localparam logic [15:0] QNAN     = 16'h7E00;

  // Unpacked operand: sig carries the hidden bit in [10].
  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [10:0] sig;
  } operand_t;

  // Denormals (exp == 0) are flushed to a signed zero significand.
  function automatic operand_t unpack_op(input logic [15:0] x);
    operand_t o;
    o.sign = x[15];
    o.exp  = x[14:10];
    o.sig  = (x[14:10] == 5'd0) ? 11'd0 : {1'b1, x[9:0]};
    return o;
  endfunction

endpackage

// File: rtl/fadd16_align.sv
// Combinational align stage: unpack both operands, put the larger
// magnitude in the big slot, and right-shift the small significand by the
// exponent difference (saturating at 14) while keeping guard, round and a
// sticky bit that collects everything shifted past the round position.
module fadd16_align
  import fadd16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        big_sign,
  output logic        eff_sub,
  output logic [4:0]  big_exp,
  output logic [10:0] big_sig,
  output logic [13:0] small_sh
);

  operand_t    ua;
  operand_t    ub;
  operand_t    big_op;
  operand_t    small_op;
  logic [4:0]  diff;
  logic [3:0]  shamt;
  logic [27:0] wide;

  // Swap on magnitude, then shift the small significand with sticky.
  always_comb begin
    ua = unpack_op(a);
    ub = unpack_op(b);
    if ({ub.exp, ub.sig} > {ua.exp, ua.sig}) begin
      big_op   = ub;
      small_op = ua;
    end else begin
      big_op   = ua;
      small_op = ub;
    end
    diff  = big_op.exp - small_op.exp;
    shamt = (diff > 5'd14) ? 4'd14 : diff[3:0];
    // Upper 14 bits are {sig, g, r, s}; lower 14 bits catch shifted-out bits.
    wide     = {small_op.sig, 3'b000, 14'd0} >> shamt;
    small_sh = {wide[27:15], wide[14] | (|wide[13:0])};
    big_sign = big_op.sign;
    eff_sub  = big_op.sign ^ small_op.sign;
    big_exp  = big_op.exp;
    big_sig  = big_op.sig;
  end

endmodule

// File: rtl/fadd16_seq.sv
// Multi-cycle binary16 adder sequencer: IDLE -> ALIGN -> ADD -> NORM ->
// PACK -> DONE, one operation in flight. The leading-zero detector lives
// outside and is driven through lzd_in / lzd_pos during NORM.
// Optional macro FADD_RNE_EN: round to nearest even in PACK; without it
// the result is truncated. Latency is the same in both builds.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is high only in IDLE; out_valid is high
// only in DONE, where sum stays stable until out_ready is seen.
module fadd16_seq
  import fadd16_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int POS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sum,
  output logic             busy,
  output logic [MAN_W:0]   lzd_in,
  input  logic [POS_W-1:0] lzd_pos
);

  // Exponent is kept two's complement with two spare bits so that
  // overflow past 31 and underflow below 1 never wrap.
  localparam int            XW      = EXP_W + 2;
  localparam int            SW      = MAN_W + 1;
  localparam int            AW      = SW + 4;     // carry, sig, g, r, s
  localparam logic [XW-1:0] EXP_OVF = XW'(EXP_MAX);

  state_t state;
  state_t state_nxt;

  logic [15:0]   op_a;
  logic [15:0]   op_b;
  logic          res_sign;
  logic          eff_sub_q;
  logic [XW-1:0] exp_q;
  logic [SW-1:0] big_sig_q;
  logic [SW+2:0] small_sh_q;
  logic [AW-1:0] acc_q;
  logic [SW-1:0] sig_q;
  logic [15:0]   sum_q;

  logic          al_big_sign;
  logic          al_eff_sub;
  logic [4:0]    al_big_exp;
  logic [10:0]   al_big_sig;
  logic [13:0]   al_small_sh;

  logic [AW-2:0] shifted;
  logic [SW-1:0] norm_sig;
  logic [2:0]    norm_grs;
  logic [XW-1:0] norm_exp;

  logic          a_nan;
  logic          b_nan;
  logic          a_inf;
  logic          b_inf;
  logic          both_neg_zero;
  logic          exp_low;
  logic          exp_high;
  logic [MAN_W-1:0] rnd_man;
  logic [XW-1:0] rnd_exp;
  logic [15:0]   pack_res;

`ifdef FADD_RNE_EN
  logic [2:0]    grs_q;
  logic          round_up;
  logic [MAN_W:0] man_inc;
`else
  logic          unused_grs;
  assign unused_grs = ^norm_grs;
`endif

  fadd16_align u_align (
    .a        (op_a),
    .b        (op_b),
    .big_sign (al_big_sign),
    .eff_sub  (al_eff_sub),
    .big_exp  (al_big_exp),
    .big_sig  (al_big_sig),
    .small_sh (al_small_sh)
  );

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: fixed walk through the datapath steps, wait in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; lzd_in is live only during NORM.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    lzd_in    = (state == NORM) ? acc_q[AW-2:3] : '0;
  end

  assign sum = sum_q;

  // Normalise: carry shifts right folding into sticky, else shift left
  // by the external leading-zero count.
  always_comb begin
    shifted = acc_q[AW-2:0] << lzd_pos;
    if (acc_q[AW-1]) begin
      norm_sig = acc_q[AW-1:4];
      norm_grs = {acc_q[3:2], acc_q[1] | acc_q[0]};
      norm_exp = exp_q + XW'(1);
    end else begin
      norm_sig = shifted[AW-2:3];
      norm_grs = shifted[2:0];
      norm_exp = exp_q - XW'(lzd_pos);
    end
  end

  // Pack: specials first, then zero, rounding, overflow and flush.
  always_comb begin
    a_nan = (op_a[14:10] == 5'h1F) && (op_a[9:0] != 10'd0);
    b_nan = (op_b[14:10] == 5'h1F) && (op_b[9:0] != 10'd0);
    a_inf = (op_a[14:10] == 5'h1F) && (op_a[9:0] == 10'd0);
    b_inf = (op_b[14:10] == 5'h1F) && (op_b[9:0] == 10'd0);
    both_neg_zero = op_a[15] && op_b[15] &&
                    (op_a[14:10] == 5'd0) && (op_b[14:10] == 5'd0);
`ifdef FADD_RNE_EN
    round_up = grs_q[2] & (grs_q[1] | grs_q[0] | sig_q[0]);
    man_inc  = {1'b0, sig_q[MAN_W-1:0]} + {{MAN_W{1'b0}}, round_up};
    rnd_man  = man_inc[MAN_W-1:0];
    rnd_exp  = man_inc[MAN_W] ? exp_q + XW'(1) : exp_q;
`else
    rnd_man  = sig_q[MAN_W-1:0];
    rnd_exp  = exp_q;
`endif
    exp_low  = rnd_exp[XW-1] || (rnd_exp == '0);
    exp_high = !rnd_exp[XW-1] && (rnd_exp >= EXP_OVF);
    if (a_nan || b_nan || (a_inf && b_inf && (op_a[15] != op_b[15])))
      pack_res = QNAN;
    else if (a_inf)
      pack_res = op_a;
    else if (b_inf)
      pack_res = op_b;
    else if (sig_q == '0)
      pack_res = both_neg_zero ? 16'h8000 : 16'h0000;
    else if (exp_high)
      pack_res = {res_sign, 5'h1F, 10'd0};
    else if (exp_low)
      pack_res = {res_sign, 15'd0};
    else
      pack_res = {res_sign, rnd_exp[EXP_W-1:0], rnd_man};
  end

  // Datapath registers, each step loading on its own state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      res_sign   <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= '0;
      big_sig_q  <= '0;
      small_sh_q <= '0;
      acc_q      <= '0;
      sig_q      <= '0;
      sum_q      <= '0;
`ifdef FADD_RNE_EN
      grs_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a <= a;
            op_b <= b;
          end
        end
        ALIGN: begin
          res_sign   <= al_big_sign;
          eff_sub_q  <= al_eff_sub;
          exp_q      <= {{(XW-EXP_W){1'b0}}, al_big_exp};
          big_sig_q  <= al_big_sig;
          small_sh_q <= al_small_sh;
        end
        ADD: begin
          if (eff_sub_q)
            acc_q <= {1'b0, big_sig_q, 3'b000} - {1'b0, small_sh_q};
          else
            acc_q <= {1'b0, big_sig_q, 3'b000} + {1'b0, small_sh_q};
        end
        NORM: begin
          sig_q <= norm_sig;
          exp_q <= norm_exp;
`ifdef FADD_RNE_EN
          grs_q <= norm_grs;
`endif
        end
        PACK: sum_q <= pack_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd16_seq.sv
// Bench for fadd16_seq: directed cases, backpressure, mid-operation reset
// and randomized operand pairs checked against an exact-arithmetic model.
module tb_fadd16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        busy;
  logic [10:0] lzd_in;
  logic [3:0]  lzd_pos;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  fadd16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy),
    .lzd_in    (lzd_in),
    .lzd_pos   (lzd_pos)
  );

  // Clock
  always #5 clk = ~clk;

  // External leading-zero detector: 11 when the input is zero.
  always_comb begin
    lzd_pos = 4'd11;
    for (int i = 0; i <= 10; i++)
      if (lzd_in[i]) lzd_pos = 4'(10 - i);
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact signed sum in units of 2^-24, then normalise and
  // truncate (or round to nearest even) at the 11-bit significand.
  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    logic [4:0] ex, ey;
    logic x_nan, y_nan, x_inf, y_inf, neg;
    longint vx, vy, tot, m, rem, half, sig;
    int p, e;
    ex = x[14:10];
    ey = y[14:10];
    x_nan = (ex == 5'd31) && (x[9:0] != 10'd0);
    y_nan = (ey == 5'd31) && (y[9:0] != 10'd0);
    x_inf = (ex == 5'd31) && (x[9:0] == 10'd0);
    y_inf = (ey == 5'd31) && (y[9:0] == 10'd0);
    if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15]))) return 16'h7E00;
    if (x_inf) return x;
    if (y_inf) return y;
    vx = (ex == 5'd0) ? 64'sd0 : (longint'({1'b1, x[9:0]}) <<< (ex - 1));
    vy = (ey == 5'd0) ? 64'sd0 : (longint'({1'b1, y[9:0]}) <<< (ey - 1));
    if (x[15]) vx = -vx;
    if (y[15]) vy = -vy;
    tot = vx + vy;
    if (tot == 0)
      return (x[15] && y[15] && ex == 5'd0 && ey == 5'd0) ? 16'h8000 : 16'h0000;
    neg = (tot < 0);
    m = neg ? -tot : tot;
    p = 0;
    for (int i = 0; i < 62; i++) if (m[i]) p = i;
    if (p >= 10) begin
      sig  = m >> (p - 10);
      rem  = m & ((64'sd1 << (p - 10)) - 1);
      half = (p > 10) ? (64'sd1 << (p - 11)) : 64'sd0;
    end else begin
      sig  = m << (10 - p);
      rem  = 0;
      half = 0;
    end
    e = p - 9;
`ifdef FADD_RNE_EN
    if (half != 0 && (rem > half || (rem == half && sig[0]))) begin
      sig++;
      if (sig == 2048) begin
        sig = 1024;
        e++;
      end
    end
`endif
    if (e >= 31) return {neg, 5'h1F, 10'd0};
    if (e <= 0)  return {neg, 15'd0};
    return {neg, 5'(e), sig[9:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [4:0] e;
    case ($urandom_range(0, 9))
      0:       e = 5'd0;
      1:       e = 5'd31;
      default: e = 5'($urandom_range(1, 30));
    endcase
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  // Driver: one full transaction with optional output backpressure.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int hold,
                        output logic [15:0] got, output logic [10:0] lz_in,
                        output logic [3:0] lz_pos);
    int cyc;
    logic ready_seen, stray_lzd, stable;
    check("idle_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    exp_q.push_back(ref_add(x, y));
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cyc = 1;
    ready_seen = 1'b0;
    stray_lzd = 1'b0;
    lz_in = '0;
    lz_pos = '0;
    while (!out_valid && cyc < 12) begin
      if (in_ready) ready_seen = 1'b1;
      if (cyc == 3) begin
        lz_in  = lzd_in;
        lz_pos = lzd_pos;
      end else if (lzd_in != 11'd0) stray_lzd = 1'b1;
      out_ready = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("latency", 16'(cyc), 16'd5);
    check("in_ready_busy", {15'd0, ready_seen}, 16'd0);
    check("lzd_outside_norm", {15'd0, stray_lzd}, 16'd0);
    got = sum;
    if (exp_q.size() > 0) check("sum", got, exp_q.pop_front());
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      if (!out_valid || sum !== got || in_ready) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", {15'd0, stable}, 16'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {14'd0, out_valid, in_ready}, 16'b01);
  endtask

  logic [15:0] dir_a [8] = '{16'h3C00, 16'h3C01, 16'h3C00, 16'h3C00,
                             16'h8000, 16'h7BFF, 16'h7C00, 16'h0001};
  logic [15:0] dir_b [8] = '{16'h3C00, 16'hBC00, 16'h3800, 16'hBC00,
                             16'h8000, 16'h7BFF, 16'hFC00, 16'h0000};
  logic [15:0] dir_e [8] = '{16'h4000, 16'h1400, 16'h3E00, 16'h0000,
                             16'h8000, 16'h7C00, 16'h7E00, 16'h0000};

  initial begin
    logic [15:0] got, x, y;
    logic [10:0] lz_in;
    logic [3:0]  lz_pos;

    // Reset
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_sum", sum, 16'h0000);
    check("rst_lzd_in", {5'd0, lzd_in}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    for (int i = 0; i < 8; i++) begin
      run_op(dir_a[i], dir_b[i], 0, got, lz_in, lz_pos);
      check("directed", got, dir_e[i]);
      if (i == 1) begin
        check("cancel_lzd_in", {5'd0, lz_in}, 16'd1);
        check("cancel_lzd_pos", {12'd0, lz_pos}, 16'd10);
      end
    end

    // Backpressure: out_ready low for 10 cycles while in_valid toggles
    run_op(16'h3C00, 16'h3C00, 10, got, lz_in, lz_pos);

    // Reset while in NORM
    check("idle_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    a = 16'h3C00;
    b = 16'h3C00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("norm_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    check("midrst_sum", sum, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h3C00, 16'h3C00, 0, got, lz_in, lz_pos);
    check("after_reset", got, 16'h4000);

    // Randomized pairs, biased toward close exponents for cancellation
    for (int i = 0; i < 60; i++) begin
      x = rand_op();
      y = rand_op();
      if ($urandom_range(0, 2) == 0) y[14:10] = x[14:10];
      if ($urandom_range(0, 3) == 0) y[15] = ~x[15];
      run_op(x, y, $urandom_range(0, 2), got, lz_in, lz_pos);
    end

    // Report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
